// File: rtl/pc_sequencer_if.sv
// Branch/control inputs and fetch-side outputs of the program-counter stage.
// master drives the decision inputs; slave is the sequencer itself.
interface pc_sequencer_if #(
  parameter int WIDTH    = 32,
  parameter int OFFSET_W = 22
);
  logic                stall;
  logic                halt;
  logic                br_taken;
  logic                br_is_reg;
  logic [OFFSET_W-1:0] br_offset;
  logic [WIDTH-1:0]    reg_target;
  logic [WIDTH-1:0]    pc_out;
  logic [WIDTH-1:0]    pc_plus4;
  logic                fetch_en;
  logic                flush;
  logic                halted;

  modport master (
    output stall, halt, br_taken, br_is_reg, br_offset, reg_target,
    input  pc_out, pc_plus4, fetch_en, flush, halted
  );

  modport slave (
    input  stall, halt, br_taken, br_is_reg, br_offset, reg_target,
    output pc_out, pc_plus4, fetch_en, flush, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Architectural PC holder: sequences fetch through boot, run, branch flush and halt.
// state  | meaning
// BOOT   | first cycle after reset, PC held, fetch disabled
// RUN    | normal fetch, PC advances or takes branches
// FLUSH  | branch shadow squashed, branch/halt inputs ignored
// HALTED | sticky halt, only reset exits
module pc_sequencer #(
  parameter int               WIDTH    = 32,
  parameter int               OFFSET_W = 22,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  localparam int EXT_W = WIDTH - OFFSET_W - 2;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    FLUSH  = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] offset_ext;
  logic [WIDTH-1:0] br_target;

  assign pc_inc     = pc + WIDTH'(4);
  assign offset_ext = {{EXT_W{bus.br_offset[OFFSET_W-1]}}, bus.br_offset, 2'b00};
  assign br_target  = bus.br_is_reg ? bus.reg_target : pc + offset_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        // halt outranks a simultaneous branch; stall outranks both
        if (!bus.stall) begin
          if (bus.halt) begin
            state_nxt = HALTED;
          end else if (bus.br_taken) begin
            pc_nxt    = br_target;
            state_nxt = FLUSH;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      FLUSH: begin
        if (!bus.stall) begin
          pc_nxt    = pc_inc;
          state_nxt = RUN;
        end
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = BOOT;
    endcase
  end

  assign bus.pc_out   = pc;
  assign bus.pc_plus4 = pc_inc;
  assign bus.fetch_en = (state == RUN) || (state == FLUSH);
  assign bus.flush    = (state == FLUSH);
  assign bus.halted   = (state == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes model predictions, monitor
// pops and compares one prediction after every rising edge.
module tb_pc_sequencer;
  localparam int WIDTH    = 32;
  localparam int OFFSET_W = 22;

  typedef struct {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc4;
    logic             fetch_en;
    logic             flush;
    logic             halted;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  pc_sequencer_if #(.WIDTH(WIDTH), .OFFSET_W(OFFSET_W)) bus ();

  pc_sequencer #(.WIDTH(WIDTH), .OFFSET_W(OFFSET_W), .RESET_PC('0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // reference model: booting, in branch shadow, halted, plus the PC value
  logic [WIDTH-1:0] m_pc;
  bit m_booting, m_shadow, m_halted;

  function automatic void model_reset();
    m_pc = '0; m_booting = 1; m_shadow = 0; m_halted = 0;
  endfunction

  function automatic void model_step(bit stall, bit halt, bit br, bit is_reg,
                                     logic signed [OFFSET_W-1:0] off,
                                     logic [WIDTH-1:0] rt);
    if (m_halted) return;
    if (m_booting) begin
      m_booting = 0;
    end else if (m_shadow) begin
      if (!stall) begin
        m_pc = m_pc + 4;
        m_shadow = 0;
      end
    end else if (!stall) begin
      if (halt) m_halted = 1;
      else if (br) begin
        m_pc = is_reg ? rt : m_pc + (WIDTH'(off) * 4);
        m_shadow = 1;
      end else m_pc = m_pc + 4;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.pc = m_pc; e.pc4 = m_pc + 4;
    e.fetch_en = !m_booting && !m_halted;
    e.flush = m_shadow; e.halted = m_halted;
    return e;
  endfunction

  task automatic check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor: the DUT presents fresh outputs after every edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.pc_out !== e.pc || bus.pc_plus4 !== e.pc4 || bus.fetch_en !== e.fetch_en ||
          bus.flush !== e.flush || bus.halted !== e.halted) begin
        n_fail++;
        $display("FAIL scoreboard @%0t: actual pc=%h p4=%h fe=%b fl=%b h=%b required pc=%h p4=%h fe=%b fl=%b h=%b",
                 $time, bus.pc_out, bus.pc_plus4, bus.fetch_en, bus.flush, bus.halted,
                 e.pc, e.pc4, e.fetch_en, e.flush, e.halted);
      end
    end
  end

  // drive one cycle at the falling edge, predict, then wait for the next falling edge
  task automatic drive(bit stall, bit halt, bit br, bit is_reg,
                       logic [OFFSET_W-1:0] off, logic [WIDTH-1:0] rt);
    bus.stall = stall; bus.halt = halt; bus.br_taken = br;
    bus.br_is_reg = is_reg; bus.br_offset = off; bus.reg_target = rt;
    model_step(stall, halt, br, is_reg, off, rt);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, $urandom_range(0, 1), OFFSET_W'($urandom), $urandom);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_pc", bus.pc_out, '0);
    check("rst_fetch_en", WIDTH'(bus.fetch_en), '0);
    @(negedge clk);
    rst = 1'b1;
    check("boot_pc", bus.pc_out, '0);
    check("boot_flags", {29'd0, bus.fetch_en, bus.flush, bus.halted}, '0);
  endtask

  initial begin
    bus.stall = 0; bus.halt = 0; bus.br_taken = 0; bus.br_is_reg = 0;
    bus.br_offset = '0; bus.reg_target = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    idle(5);
    check("run_pc_0x10", bus.pc_out, 32'h10);
    drive(0, 0, 1, 0, 22'h3FFFFE, $urandom);
    check("rel_branch_pc", bus.pc_out, 32'h08);
    check("rel_branch_flush", WIDTH'(bus.flush), 1);
    drive(0, $urandom_range(0, 1), 1, 1, OFFSET_W'($urandom), $urandom);
    check("after_flush_pc", bus.pc_out, 32'h0C);
    check("after_flush_flag", WIDTH'(bus.flush), 0);

    idle(5);
    check("run_pc_0x20", bus.pc_out, 32'h20);
    drive(0, 0, 1, 1, OFFSET_W'($urandom), 32'hFFFF_FFFC);
    check("reg_branch_pc", bus.pc_out, 32'hFFFF_FFFC);
    check("reg_branch_plus4_wrap", bus.pc_plus4, 32'h0);
    idle(1);
    check("wrap_pc", bus.pc_out, 32'h0);

    idle(16);
    check("run_pc_0x40", bus.pc_out, 32'h40);
    for (int i = 0; i < 3; i++) drive(1, $urandom_range(0, 1), $urandom_range(0, 1), 1, '0, $urandom);
    check("stall_run_pc", bus.pc_out, 32'h40);
    drive(0, 0, 1, 1, '0, 32'h0000_0100);
    drive(1, 0, 0, 0, '0, '0);
    drive(1, 1, 1, 0, '0, '0);
    check("stall_flush_held", WIDTH'(bus.flush), 1);
    drive(0, 0, 0, 0, '0, '0);
    check("flush_release_pc", bus.pc_out, 32'h104);

    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1), OFFSET_W'($urandom), $urandom);

    do_reset();
    idle(13);
    check("run_pc_0x30", bus.pc_out, 32'h30);
    drive(0, 1, 1, 1, OFFSET_W'($urandom), $urandom);
    for (int i = 0; i < 10; i++)
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), OFFSET_W'($urandom), $urandom);
    check("halt_pc", bus.pc_out, 32'h30);
    check("halt_flags", {29'd0, bus.fetch_en, bus.flush, bus.halted}, 32'h1);

    do_reset();
    idle(3);
    drive(0, 0, 1, 1, '0, 32'h0000_0200);
    drive(1, 0, 0, 0, '0, '0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("async_rst_pc", bus.pc_out, '0);
    check("async_rst_flags", {29'd0, bus.fetch_en, bus.flush, bus.halted}, '0);
    @(negedge clk);
    rst = 1'b1;
    idle(4);
    check("recover_pc", bus.pc_out, 32'h0C);

    repeat (2) @(negedge clk);
    check("queue_drained", WIDTH'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
